// File: rtl/cpa_seq_ctrl.sv
// Multi-word add/subtract sequencer driving one external 4-bit CPA slice,
// one nibble per clock, LSB first, with the ripple carry held in a register.
module cpa_seq_ctrl #(
  parameter int N_SLICES = 4,
  localparam int W = 4 * N_SLICES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sub,
  input  logic         c_in,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] s,
  output logic         c_out,
  output logic         ovf,
  output logic [3:0]   cpa_a,
  output logic [3:0]   cpa_b,
  output logic         cpa_c_in,
  input  logic [3:0]   cpa_s,
  input  logic         cpa_c_out
);

  localparam int IDX_W = (N_SLICES > 1) ? $clog2(N_SLICES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   idx_reg;
  logic [W-1:0]       ra_reg, rb_reg;
  logic               cr_reg;
  logic               c_out_reg, ovf_reg;
  logic [3:0]         s_reg  [N_SLICES];
  logic [3:0]         ra_nib [N_SLICES];
  logic [3:0]         rb_nib [N_SLICES];
  logic               last_slice;

  assign last_slice = (idx_reg == IDX_W'(N_SLICES - 1));

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_slice) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_reg != IDLE);
    done     = (state_reg == DONE);
    cpa_a    = 4'd0;
    cpa_b    = 4'd0;
    cpa_c_in = 1'b0;
    if (state_reg == RUN) begin
      cpa_a    = ra_nib[idx_reg];
      cpa_b    = rb_nib[idx_reg];
      cpa_c_in = cr_reg;
    end
  end

  // Subtract is a + ~b + 1: B is inverted once at latch time, carry seeded with 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_reg   <= '0;
      ra_reg    <= '0;
      rb_reg    <= '0;
      cr_reg    <= 1'b0;
      c_out_reg <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            ra_reg  <= a;
            rb_reg  <= sub ? ~b : b;
            cr_reg  <= sub ? 1'b1 : c_in;
            idx_reg <= '0;
          end
        end
        RUN: begin
          cr_reg <= cpa_c_out;
          if (last_slice) begin
            c_out_reg <= cpa_c_out;
            ovf_reg   <= (ra_reg[W-1] == rb_reg[W-1]) && (cpa_s[3] != ra_reg[W-1]);
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < N_SLICES; gi++) begin : g_slice
      assign ra_nib[gi]      = ra_reg[4*gi +: 4];
      assign rb_nib[gi]      = rb_reg[4*gi +: 4];
      assign s[4*gi +: 4]    = s_reg[gi];

      always_ff @(posedge clk) begin
        if (rst)
          s_reg[gi] <= 4'd0;
        else if (state_reg == RUN && idx_reg == IDX_W'(gi))
          s_reg[gi] <= cpa_s;
      end
    end
  endgenerate

  assign c_out = c_out_reg;
  assign ovf   = ovf_reg;

endmodule

// File: tb/tb_cpa_seq_ctrl.sv
// Bench for cpa_seq_ctrl: external CPA modelled inline, directed vectors feed a
// scoreboard that a negedge monitor drains on each done pulse.
module tb_cpa_seq_ctrl;

  localparam int N = 4;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst, start, sub, c_in;
  logic [W-1:0] a, b;
  logic         busy, done, c_out, ovf;
  logic [W-1:0] s;
  logic [3:0]   cpa_a, cpa_b, cpa_s;
  logic         cpa_c_in, cpa_c_out;

  cpa_seq_ctrl #(.N_SLICES(N)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .c_in(c_in),
    .a(a), .b(b), .busy(busy), .done(done), .s(s), .c_out(c_out), .ovf(ovf),
    .cpa_a(cpa_a), .cpa_b(cpa_b), .cpa_c_in(cpa_c_in),
    .cpa_s(cpa_s), .cpa_c_out(cpa_c_out)
  );

  // The shared combinational 4-bit adder slice
  assign {cpa_c_out, cpa_s} = {1'b0, cpa_a} + {1'b0, cpa_b} + {4'd0, cpa_c_in};

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         v;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  logic cq[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   done_cnt = 0;
  logic prev_done = 1'b0;
  logic prev_idle = 1'b0;
  logic [W-1:0] prev_s;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on done, checks per-slice carry while running
  always @(negedge clk) begin
    if (!rst) begin
      if (done === 1'b1) begin
        done_cnt++;
        chk("done_single_pulse", {31'd0, prev_done}, 32'd0);
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          $display("done: s=%h c_out=%b ovf=%b (expected %h %b %b)", s, c_out, ovf, e.s, e.c, e.v);
          chk("result_s", {16'd0, s}, {16'd0, e.s});
          chk("result_c_out", {31'd0, c_out}, {31'd0, e.c});
          chk("result_ovf", {31'd0, ovf}, {31'd0, e.v});
          chk("done_latency", cyc, e.cyc);
        end
      end else if (busy === 1'b1 && cq.size() != 0) begin
        logic ec;
        ec = cq.pop_front();
        chk("slice_cpa_c_in", {31'd0, cpa_c_in}, {31'd0, ec});
      end
      if (busy === 1'b0) begin
        chk("idle_cpa_zero", {23'd0, cpa_a, cpa_b, cpa_c_in}, 32'd0);
        if (prev_idle) chk("idle_s_stable", {16'd0, s}, {16'd0, prev_s});
      end
      prev_done = (done === 1'b1);
      prev_idle = (busy === 1'b0);
      prev_s    = s;
    end else begin
      prev_done = 1'b0;
      prev_idle = 1'b0;
    end
  end

  task automatic wait_idle();
    int k = 0;
    @(negedge clk);
    while (busy !== 1'b0) begin
      k++;
      if (k > 20) begin
        $display("FAIL wait_idle: busy stuck at %b after 20 cycles", busy);
        $fatal(1, "timeout");
      end
      @(negedge clk);
    end
  endtask

  task automatic expect_op(input logic [W-1:0] es, input logic ec, input logic ev,
                           input logic [3:0] cseq);
    exp_t e;
    e.s = es; e.c = ec; e.v = ev; e.cyc = cyc + N;
    sb.push_back(e);
    for (int i = 0; i < N; i++) cq.push_back(cseq[i]);
  endtask

  // cseq bit i = carry into slice i
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tsub,
                       input logic tcin, input logic [W-1:0] es, input logic ec,
                       input logic ev, input logic [3:0] cseq);
    wait_idle();
    a = ta; b = tb_v; sub = tsub; c_in = tcin; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = ~ta; b = ~tb_v; sub = ~tsub; c_in = ~tcin;
    expect_op(es, ec, ev, cseq);
    $display("op: a=%h b=%h sub=%b c_in=%b", ta, tb_v, tsub, tcin);
    wait_idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    rst = 1'b1; start = 1'b0; sub = 1'b0; c_in = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_s", {16'd0, s}, 32'd0);
    chk("reset_flags", {30'd0, c_out, ovf}, 32'd0);
    rst = 1'b0;

    do_op(16'h1234, 16'h0FCD, 1'b0, 1'b0, 16'h2201, 1'b0, 1'b0, 4'b1110);
    do_op(16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 4'b1111);
    do_op(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 4'b0001);
    do_op(16'h0007, 16'h0005, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b0, 4'b1111);
    do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 4'b1110);
    do_op(16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 4'b0001);

    // start held high, operands change every cycle; ops accepted at k = 0, 6, 12
    wait_idle();
    d0 = done_cnt;
    for (int k = 0; k < 18; k++) begin
      a = 16'h1000 + 16'(k);
      b = 16'(k) << 8;
      sub = (k % 4 == 0) && (k > 0);
      c_in = k[0];
      start = 1'b1;
      @(posedge clk);
      #1;
      if (k == 0)  expect_op(16'h1000, 1'b0, 1'b0, 4'b0000);
      if (k == 6)  expect_op(16'h1606, 1'b0, 1'b0, 4'b0000);
      if (k == 12) expect_op(16'h040C, 1'b1, 1'b0, 4'b0111);
      if (k < 17) @(negedge clk);
    end
    start = 1'b0;
    wait_idle();
    chk("handshake_op_count", done_cnt - d0, 32'd3);

    // reset in the cycle where idx = 2; no result expected from this op
    wait_idle();
    a = 16'h1234; b = 16'h0FCD; sub = 1'b0; c_in = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_s", {16'd0, s}, 32'd0);
    chk("midrst_flags", {30'd0, c_out, ovf}, 32'd0);
    chk("midrst_cpa", {23'd0, cpa_a, cpa_b, cpa_c_in}, 32'd0);

    do_op(16'hA5A5, 16'h5A5A, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 4'b1111);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);
    chk("carry_queue_drained", cq.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
